// File: rtl/csr_trap_unit_pkg.sv
// Shared constants for the machine-mode CSR file and trap controller:
// CSR addresses, cause codes, mstatus bit positions, system-op encodings, FSM states.
package csr_trap_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    localparam logic [4:0] CAUSE_BREAKPOINT = 5'd3;
    localparam logic [4:0] CAUSE_ECALL_M    = 5'd11;
    localparam logic [4:0] IRQ_M_SW         = 5'd3;
    localparam logic [4:0] IRQ_M_TIMER      = 5'd7;
    localparam logic [4:0] IRQ_M_EXT        = 5'd11;
    localparam int         IRQ_LOCAL_BASE   = 16;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [1:0] SYS_ECALL  = 2'd0;
    localparam logic [1:0] SYS_EBREAK = 2'd1;
    localparam logic [1:0] SYS_MRET   = 2'd2;
    localparam logic [1:0] SYS_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENTER = 2'd2
    } trap_state_e;

    // Standard enables (sw/timer/ext) plus one bit per local line from bit 16 up.
    function automatic logic [31:0] mie_mask(input int n);
        return 32'h0000_0888 | (((32'h1 << n) - 32'h1) << 16);
    endfunction

endpackage

// File: rtl/csr_trap_unit_irq_arbiter.sv
// Fixed-priority interrupt encoder: ext > sw > timer > local[0] > local[1] > ...
// Produces the winning cause code from the pending vector.
module csr_irq_arbiter
    import csr_trap_unit_pkg::*;
#(
    parameter int NUM_LOCAL_IRQ = 4
) (
    input  logic [31:0] pend,
    output logic        valid,
    output logic [4:0]  cause
);

    localparam logic [31:0] USED_MASK = mie_mask(NUM_LOCAL_IRQ);

    logic [31:0] unused_pend;
    assign unused_pend = pend & ~USED_MASK;

    // Later assignments override earlier ones, so lowest priority goes first.
    always_comb begin
        valid = 1'b0;
        cause = 5'd0;
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
            if (pend[IRQ_LOCAL_BASE + i]) begin
                valid = 1'b1;
                cause = 5'(IRQ_LOCAL_BASE + i);
            end
        end
        if (pend[IRQ_M_TIMER]) begin
            valid = 1'b1;
            cause = IRQ_M_TIMER;
        end
        if (pend[IRQ_M_SW]) begin
            valid = 1'b1;
            cause = IRQ_M_SW;
        end
        if (pend[IRQ_M_EXT]) begin
            valid = 1'b1;
            cause = IRQ_M_EXT;
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with 64-bit counters, local interrupts, vectored mtvec
// and an IDLE/DRAIN/ENTER trap-entry sequencer driving the fetch redirect.
//
// state    | meaning
// ST_IDLE  | normal execution; syscalls act on advance, pending irq starts a drain
// ST_DRAIN | drain_req high; counting advance strobes, irq is committed
// ST_ENTER | one cycle: save pc_resume/cause, mask interrupts, pulse redirect
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter int          DRAIN_CYCLES  = 13,
    parameter bit          VECTORED_EN   = 1'b1,
    parameter logic [31:0] MISA_VALUE    = 32'h4000_0100
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [11:0]              csr_raddr,
    output logic [31:0]              csr_rdata,
    input  logic [11:0]              csr_waddr,
    input  logic                     csr_wen,
    input  logic [31:0]              csr_wdata,
    input  logic                     advance,
    input  logic                     retire,
    input  logic                     sys_valid,
    input  logic [1:0]               sys_code,
    input  logic [31:0]              pc_id,
    input  logic [31:0]              pc_resume,
    input  logic                     irq_sw,
    input  logic                     irq_timer,
    input  logic                     irq_ext,
    input  logic [NUM_LOCAL_IRQ-1:0] irq_local,
    output logic                     drain_req,
    output logic                     trap_redirect,
    output logic [31:0]              trap_target,
    output logic                     int_taken
);

    localparam int          CW         = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES);
    localparam logic [31:0] MIE_MASK   = mie_mask(NUM_LOCAL_IRQ);
    localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
    localparam logic [31:0] EPC_MASK   = 32'hFFFF_FFFC;

    trap_state_e   state, state_next;
    logic [CW-1:0] drain_cnt, drain_cnt_next;
    logic [4:0]    cause_q, cause_next;
    logic [31:0]   target_q, target_next;

    logic [31:0] mstatus, mstatus_next;
    logic [31:0] mie, mtvec, mscratch, mepc, mcause, mtval, mip;
    logic [63:0] mcycle, mcycle_next, minstret, minstret_next;
    logic [31:0] rd_val;

    logic        wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
    logic        wr_mcycle_lo, wr_mcycle_hi, wr_minstret_lo, wr_minstret_hi;
    logic        sys_fire, exc_fire, mret_fire, irq_fire, enter;
    logic [31:0] pend;
    logic        irq_valid;
    logic [4:0]  irq_cause;
    logic [31:0] trap_base, irq_target, mret_target;
    logic [4:0]  exc_cause;

    always_comb begin
        wr_mstatus     = csr_wen && (csr_waddr == CSR_MSTATUS);
        wr_mie         = csr_wen && (csr_waddr == CSR_MIE);
        wr_mtvec       = csr_wen && (csr_waddr == CSR_MTVEC);
        wr_mscratch    = csr_wen && (csr_waddr == CSR_MSCRATCH);
        wr_mepc        = csr_wen && (csr_waddr == CSR_MEPC);
        wr_mcause      = csr_wen && (csr_waddr == CSR_MCAUSE);
        wr_mtval       = csr_wen && (csr_waddr == CSR_MTVAL);
        wr_mcycle_lo   = csr_wen && (csr_waddr == CSR_MCYCLE);
        wr_mcycle_hi   = csr_wen && (csr_waddr == CSR_MCYCLEH);
        wr_minstret_lo = csr_wen && (csr_waddr == CSR_MINSTRET);
        wr_minstret_hi = csr_wen && (csr_waddr == CSR_MINSTRETH);
    end

    always_comb begin
        mip = 32'h0;
        mip[IRQ_M_SW]    = irq_sw;
        mip[IRQ_M_TIMER] = irq_timer;
        mip[IRQ_M_EXT]   = irq_ext;
        mip[IRQ_LOCAL_BASE +: NUM_LOCAL_IRQ] = irq_local;
    end

    assign pend = mip & mie & {32{mstatus[MSTATUS_MIE]}};

    csr_irq_arbiter #(
        .NUM_LOCAL_IRQ(NUM_LOCAL_IRQ)
    ) u_arbiter (
        .pend (pend),
        .valid(irq_valid),
        .cause(irq_cause)
    );

    // Reserved sys_code is treated as no system op, so an interrupt may still start.
    assign sys_fire  = (state == ST_IDLE) && advance && sys_valid && (sys_code != SYS_RSVD);
    assign exc_fire  = sys_fire && ((sys_code == SYS_ECALL) || (sys_code == SYS_EBREAK));
    assign mret_fire = sys_fire && (sys_code == SYS_MRET);
    assign irq_fire  = (state == ST_IDLE) && advance && !sys_fire && irq_valid;
    assign enter     = (state == ST_ENTER);
    assign exc_cause = (sys_code == SYS_EBREAK) ? CAUSE_BREAKPOINT : CAUSE_ECALL_M;

    assign trap_base   = {mtvec[31:2], 2'b00};
    assign irq_target  = mtvec[0] ? (trap_base + {25'd0, irq_cause, 2'b00}) : trap_base;
    assign mret_target = wr_mepc ? (csr_wdata & EPC_MASK) : mepc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            cause_q   <= 5'd0;
            target_q  <= 32'h0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            cause_q   <= cause_next;
            target_q  <= target_next;
        end
    end

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        cause_next     = cause_q;
        target_next    = target_q;
        drain_req      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (irq_fire) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = '0;
                    cause_next     = irq_cause;
                    target_next    = irq_target;
                end
            end
            ST_DRAIN: begin
                drain_req = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = ST_ENTER;
                end else if (advance) begin
                    drain_cnt_next = drain_cnt + CW'(1);
                end
            end
            ST_ENTER: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Trap hardware owns MIE/MPIE on entry and mret; a same-cycle write supplies the rest.
    always_comb begin
        mstatus_next = mstatus;
        if (wr_mstatus) begin
            mstatus_next = csr_wdata;
        end
        if (exc_fire || enter) begin
            mstatus_next[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
            mstatus_next[MSTATUS_MIE]  = 1'b0;
        end else if (mret_fire) begin
            mstatus_next[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
            mstatus_next[MSTATUS_MPIE] = 1'b1;
        end
    end

    always_comb begin
        mcycle_next = mcycle + 64'd1;
        if (wr_mcycle_lo) begin
            mcycle_next = {mcycle[63:32], csr_wdata};
        end else if (wr_mcycle_hi) begin
            mcycle_next = {csr_wdata, mcycle[31:0]};
        end
        minstret_next = retire ? (minstret + 64'd1) : minstret;
        if (wr_minstret_lo) begin
            minstret_next = {minstret[63:32], csr_wdata};
        end else if (wr_minstret_hi) begin
            minstret_next = {csr_wdata, minstret[31:0]};
        end
    end

    always_comb begin
        rd_val = 32'h0;
        case (csr_raddr)
            CSR_MSTATUS:                 rd_val = mstatus;
            CSR_MISA:                    rd_val = MISA_VALUE;
            CSR_MIE:                     rd_val = mie;
            CSR_MTVEC:                   rd_val = mtvec;
            CSR_MSCRATCH:                rd_val = mscratch;
            CSR_MEPC:                    rd_val = mepc;
            CSR_MCAUSE:                  rd_val = mcause;
            CSR_MTVAL:                   rd_val = mtval;
            CSR_MIP:                     rd_val = mip;
            CSR_MCYCLE, CSR_CYCLE:       rd_val = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:     rd_val = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   rd_val = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rd_val = minstret[63:32];
            default:                     rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mstatus       <= 32'h0;
            mie           <= 32'h0;
            mtvec         <= 32'h0;
            mscratch      <= 32'h0;
            mepc          <= 32'h0;
            mcause        <= 32'h0;
            mtval         <= 32'h0;
            mcycle        <= 64'h0;
            minstret      <= 64'h0;
            csr_rdata     <= 32'h0;
            trap_redirect <= 1'b0;
            trap_target   <= 32'h0;
            int_taken     <= 1'b0;
        end else begin
            mstatus  <= mstatus_next;
            mcycle   <= mcycle_next;
            minstret <= minstret_next;
            if (wr_mie) begin
                mie <= csr_wdata & MIE_MASK;
            end
            if (wr_mtvec) begin
                mtvec <= csr_wdata & MTVEC_MASK;
            end
            if (wr_mscratch) begin
                mscratch <= csr_wdata;
            end
            if (wr_mtval) begin
                mtval <= csr_wdata;
            end

            if (exc_fire) begin
                mepc   <= pc_id & EPC_MASK;
                mcause <= {27'd0, exc_cause};
            end else if (enter) begin
                mepc   <= pc_resume & EPC_MASK;
                mcause <= {1'b1, 26'd0, cause_q};
            end else begin
                if (wr_mepc) begin
                    mepc <= csr_wdata & EPC_MASK;
                end
                if (wr_mcause) begin
                    mcause <= csr_wdata;
                end
            end

            trap_redirect <= exc_fire || mret_fire || enter;
            int_taken     <= enter;
            if (exc_fire) begin
                trap_target <= trap_base;
            end else if (mret_fire) begin
                trap_target <= mret_target;
            end else if (enter) begin
                trap_target <= target_q;
            end

            csr_rdata <= (csr_wen && (csr_raddr == csr_waddr)) ? csr_wdata : rd_val;
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: CSR access, syscalls, interrupt drain/entry,
// counters and reset abort, each step checked against hand-computed values.
module tb_csr_trap_unit;
    import csr_trap_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] csr_raddr = 12'h0;
    logic [31:0] csr_rdata;
    logic [11:0] csr_waddr = 12'h0;
    logic        csr_wen = 1'b0;
    logic [31:0] csr_wdata = 32'h0;
    logic        advance = 1'b0;
    logic        retire = 1'b0;
    logic        sys_valid = 1'b0;
    logic [1:0]  sys_code = 2'd0;
    logic [31:0] pc_id = 32'h0;
    logic [31:0] pc_resume = 32'h0;
    logic        irq_sw = 1'b0;
    logic        irq_timer = 1'b0;
    logic        irq_ext = 1'b0;
    logic [3:0]  irq_local = 4'h0;
    logic        drain_req;
    logic        trap_redirect;
    logic [31:0] trap_target;
    logic        int_taken;

    always #5 clock = ~clock;

    csr_trap_unit #(
        .NUM_LOCAL_IRQ(4),
        .DRAIN_CYCLES (13),
        .VECTORED_EN  (1'b1),
        .MISA_VALUE   (32'h4000_0100)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .csr_raddr    (csr_raddr),
        .csr_rdata    (csr_rdata),
        .csr_waddr    (csr_waddr),
        .csr_wen      (csr_wen),
        .csr_wdata    (csr_wdata),
        .advance      (advance),
        .retire       (retire),
        .sys_valid    (sys_valid),
        .sys_code     (sys_code),
        .pc_id        (pc_id),
        .pc_resume    (pc_resume),
        .irq_sw       (irq_sw),
        .irq_timer    (irq_timer),
        .irq_ext      (irq_ext),
        .irq_local    (irq_local),
        .drain_req    (drain_req),
        .trap_redirect(trap_redirect),
        .trap_target  (trap_target),
        .int_taken    (int_taken)
    );

    int total = 0;
    int passed = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
        csr_raddr = addr;
        tick();
        data = csr_rdata;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_wen   = 1'b1;
        csr_waddr = addr;
        csr_wdata = data;
        tick();
        csr_wen   = 1'b0;
    endtask

    task automatic wait_redirect(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!trap_redirect && n < 60);
    endtask

    initial begin
        logic [31:0] rd;
        int          n;
        logic        drain_ok;
        int          bad;

        // 1: reset state and read-only CSRs
        tick();
        tick();
        check("rst_rdata", csr_rdata, 32'h0);
        check("rst_outputs", {28'd0, drain_req, trap_redirect, int_taken, 1'b0}, 32'h0);
        check("rst_target", trap_target, 32'h0);
        reset = 1'b1;
        tick();
        csr_read(CSR_MISA, rd);
        check("misa", rd, 32'h4000_0100);
        irq_ext = 1'b1;
        csr_read(CSR_MIP, rd);
        check("mip_ext", rd, 32'h0000_0800);
        irq_ext = 1'b0;
        csr_read(CSR_MSTATUS, rd);
        check("rst_mstatus", rd, 32'h0);

        // 2: vectored timer interrupt through a full drain
        csr_write(CSR_MTVEC, 32'h0000_1001);
        csr_write(CSR_MIE, 32'h0000_0080);
        csr_write(CSR_MSTATUS, 32'h0000_0008);
        csr_read(CSR_MTVEC, rd);
        check("mtvec_rb", rd, 32'h0000_1001);
        irq_timer = 1'b1;
        pc_resume = 32'h0000_3008;
        advance   = 1'b1;
        tick();
        check("drain_start", 32'(drain_req), 32'h1);
        drain_ok = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (!drain_req || trap_redirect) drain_ok = 1'b0;
            if (i == 5) irq_timer = 1'b0;
            tick();
        end
        check("drain_held", 32'(drain_ok), 32'h1);
        check("drain_after_13", 32'(drain_req), 32'h1);
        advance = 1'b0;
        wait_redirect(n);
        check("drain_latency", 32'(n), 32'd2);
        check("irq_target", trap_target, 32'h0000_101C);
        check("irq_int_taken", 32'(int_taken), 32'h1);
        tick();
        check("pulse_width", {30'd0, trap_redirect, int_taken}, 32'h0);
        csr_read(CSR_MCAUSE, rd);
        check("irq_mcause", rd, 32'h8000_0007);
        csr_read(CSR_MSTATUS, rd);
        check("irq_mstatus", rd, 32'h0000_0080);
        csr_read(CSR_MEPC, rd);
        check("irq_mepc", rd, 32'h0000_3008);

        // 3: ecall, then mret with forwarded mepc write
        csr_write(CSR_MSTATUS, 32'h0000_0008);
        sys_valid = 1'b1;
        sys_code  = SYS_ECALL;
        pc_id     = 32'h0000_0200;
        advance   = 1'b1;
        tick();
        sys_valid = 1'b0;
        advance   = 1'b0;
        check("ecall_redirect", {30'd0, trap_redirect, int_taken}, 32'h2);
        check("ecall_target", trap_target, 32'h0000_1000);
        csr_read(CSR_MEPC, rd);
        check("ecall_mepc", rd, 32'h0000_0200);
        csr_read(CSR_MCAUSE, rd);
        check("ecall_mcause", rd, 32'd11);
        csr_read(CSR_MSTATUS, rd);
        check("ecall_mstatus", rd, 32'h0000_0080);
        sys_valid = 1'b1;
        sys_code  = SYS_MRET;
        advance   = 1'b1;
        csr_wen   = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = 32'h0000_0204;
        tick();
        sys_valid = 1'b0;
        advance   = 1'b0;
        csr_wen   = 1'b0;
        check("mret_redirect", 32'(trap_redirect), 32'h1);
        check("mret_target", trap_target, 32'h0000_0204);
        csr_read(CSR_MSTATUS, rd);
        check("mret_mstatus", rd, 32'h0000_0088);

        // 4: priority ext over local[0]; then local[2] alone; ebreak beats irq
        csr_write(CSR_MIE, 32'h0005_0800);
        irq_ext   = 1'b1;
        irq_local = 4'b0001;
        advance   = 1'b1;
        wait_redirect(n);
        advance   = 1'b0;
        irq_ext   = 1'b0;
        irq_local = 4'b0000;
        check("ext_latency", 32'(n), 32'd16);
        check("ext_target", trap_target, 32'h0000_102C);
        csr_read(CSR_MCAUSE, rd);
        check("ext_mcause", rd, 32'h8000_000B);
        csr_write(CSR_MSTATUS, 32'h0000_0008);
        irq_local = 4'b0100;
        advance   = 1'b1;
        wait_redirect(n);
        advance   = 1'b0;
        check("local2_target", trap_target, 32'h0000_1048);
        csr_read(CSR_MCAUSE, rd);
        check("local2_mcause", rd, 32'h8000_0012);
        csr_write(CSR_MSTATUS, 32'h0000_0008);
        sys_valid = 1'b1;
        sys_code  = SYS_EBREAK;
        pc_id     = 32'h0000_0300;
        advance   = 1'b1;
        tick();
        sys_valid = 1'b0;
        advance   = 1'b0;
        check("ebreak_redirect", {29'd0, trap_redirect, int_taken, drain_req}, 32'h4);
        check("ebreak_target", trap_target, 32'h0000_1000);
        tick();
        check("ebreak_no_drain", 32'(drain_req), 32'h0);
        irq_local = 4'b0000;
        csr_read(CSR_MCAUSE, rd);
        check("ebreak_mcause", rd, 32'd3);

        // 5: counters, bypass, masks, unimplemented addresses
        csr_write(CSR_MCYCLE, 32'hFFFF_FFFF);
        csr_write(CSR_MCYCLEH, 32'h0);
        tick();
        csr_read(CSR_MCYCLE, rd);
        check("mcycle_lo_wrap", rd, 32'h0);
        csr_read(CSR_CYCLEH, rd);
        check("mcycle_hi_carry", rd, 32'h1);
        retire = 1'b1;
        csr_write(CSR_MINSTRET, 32'h0000_0055);
        tick();
        tick();
        tick();
        retire = 1'b0;
        csr_read(CSR_INSTRET, rd);
        check("minstret_count", rd, 32'h0000_0058);
        csr_raddr = CSR_MSCRATCH;
        csr_write(CSR_MSCRATCH, 32'hDEAD_BEEF);
        check("bypass", csr_rdata, 32'hDEAD_BEEF);
        csr_write(CSR_MIE, 32'hFFFF_FFFF);
        csr_read(CSR_MIE, rd);
        check("mie_mask", rd, 32'h000F_0888);
        csr_write(CSR_MISA, 32'h0);
        csr_write(12'h7C0, 32'h1234_5678);
        csr_read(CSR_MISA, rd);
        check("misa_ro", rd, 32'h4000_0100);
        csr_read(12'h7C0, rd);
        check("unimpl_read", rd, 32'h0);
        csr_write(CSR_MEPC, 32'h0000_0207);
        csr_read(CSR_MEPC, rd);
        check("mepc_mask", rd, 32'h0000_0204);

        // 6: reset in the middle of a drain
        csr_write(CSR_MSTATUS, 32'h0000_0008);
        irq_timer = 1'b1;
        advance   = 1'b1;
        tick();
        check("rst_drain_start", 32'(drain_req), 32'h1);
        tick();
        tick();
        advance = 1'b0;
        reset   = 1'b0;
        #1;
        check("rst_abort", {30'd0, drain_req, trap_redirect}, 32'h0);
        irq_timer = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (trap_redirect || drain_req || int_taken) bad++;
        end
        check("rst_no_pulse", 32'(bad), 32'd0);
        csr_read(CSR_MEPC, rd);
        check("rst_mepc", rd, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
Parametrised machine-mode CSR file and trap controller for the RISC-V core. Adds four things to the base CSR block: 64-bit cycle and instret counters, N platform local interrupts (mip/mie bits 16+), vectored mtvec mode, and an explicit IDLE/DRAIN/ENTER trap-entry FSM. Sits beside the ID stage. Drives the PC redirect to the fetch unit and receives commit/advance strobes from the pipeline.

Parameters:
NUM_LOCAL_IRQ, 4, number of local interrupt lines; uses mip/mie bits 16..16+N-1 (1..16 allowed)
DRAIN_CYCLES, 13, number of advance strobes to count before trap entry
VECTORED_EN, 1, 1 allows mtvec.MODE=1 (vectored); 0 forces direct mode
MISA_VALUE, 32'h40000100, read-only misa contents (RV32I)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
csr_raddr  in  12  read address
csr_rdata  out  32  registered read data, 1-cycle latency
csr_waddr  in  12  write address
csr_wen  in  1  write enable
csr_wdata  in  32  write data
advance  in  1  pipeline advances this cycle (write_pc)
retire  in  1  one instruction retired this cycle
sys_valid  in  1  system instruction in ID
sys_code  in  2  0 ecall, 1 ebreak, 2 mret, 3 reserved (ignored)
pc_id  in  32  PC of the instruction in ID
pc_resume  in  32  resume PC presented at the end of drain
irq_sw, irq_timer, irq_ext  in  1 each  standard interrupt levels
irq_local  in  NUM_LOCAL_IRQ  local interrupt levels
drain_req  out  1  high while in DRAIN; pipeline must stop fetching new work
trap_redirect  out  1  one-cycle pulse: load trap_target into the PC
trap_target  out  32  redirect target
int_taken  out  1  one-cycle pulse on asynchronous interrupt entry

Behaviour:
- Reset values:
  - csr_rdata, drain_req, trap_redirect, int_taken, trap_target all = 0.
  - All CSRs = 0 except misa = MISA_VALUE. Counters = 0. FSM = IDLE.
  - Reset mid-drain aborts the drain with no CSR side effects.
- Implemented CSR map:
  - 300 mstatus, 301 misa (read-only), 304 mie, 305 mtvec, 340 mscratch, 341 mepc, 342 mcause, 343 mtval, 344 mip (read-only).
  - B00/B80 mcycle lo/hi, B02/B82 minstret lo/hi.
  - C00/C80/C02/C82 read-only aliases of the counters.
  - Unimplemented addresses read 0; writes to them are dropped.
- Read path:
  - csr_rdata <= (csr_wen && csr_raddr == csr_waddr) ? csr_wdata : CSR value.
  - Bypass applies only when csr_wen=1.
- Write masks:
  - mepc[1:0] forced to 0.
  - mtvec[1] forced to 0. mtvec[0] is kept only when VECTORED_EN=1.
  - mie writable bits: 3, 7, 11, 16..16+N-1; all others read 0.
- mip = {local bits at 16.., ext at 11, timer at 7, sw at 3}; live, not latched.
- Counters:
  - mcycle increments every cycle; minstret increments when retire=1.
  - Each is 64 bits; the low-word carry propagates into the high word in the same cycle.
  - A CSR write to either half overrides that cycle's increment of the whole counter.
- Pending interrupt: pend = mip & mie & {32{mstatus.MIE}}.
- Interrupt priority: ext(11) > sw(3) > timer(7) > local, lowest local index first.
- Target computation:
  - Exceptions and mret: base = {mtvec[31:2], 2'b00}.
  - Interrupts: base + 4*cause_code when mtvec[0]=1, else base.
- FSM, IDLE, on advance=1:
  - sys_valid with ecall/ebreak:
    - mepc <= pc_id; mcause <= 11 or 3.
    - MPIE <= MIE; MIE <= 0.
    - trap_redirect=1 next cycle with target = base.
  - sys_valid with mret:
    - MIE <= MPIE; MPIE <= 1.
    - Target = mepc, or csr_wdata when the same cycle writes 341 (forwarded).
  - Otherwise, if pend != 0:
    - Latch the winning cause into cause_q and the target into target_q.
    - Counter <= 0; go to DRAIN. Syscall always beats an interrupt in the same cycle.
- FSM, DRAIN:
  - drain_req=1; counter increments on each advance.
  - sys_valid is ignored.
  - Deassertion of the interrupt does not cancel the drain (it is committed).
  - When counter == DRAIN_CYCLES, go to ENTER.
- FSM, ENTER (one cycle):
  - mepc <= pc_resume; mcause <= {1, cause_q}.
  - MPIE <= MIE; MIE <= 0.
  - trap_redirect and int_taken pulse.
  - Then return to IDLE.
- Same-cycle CSR write to mstatus during trap entry or mret: the trap hardware wins on bits 3 and 7; the write supplies all other bits.

Decomposition:
- Shared constants include (next to constants.vh): CSR address macros, cause codes, mstatus bit indices, sys_code encodings, FSM state encodings.
- One sub-module, csr_irq_arbiter: combinational priority encoder from pend to {valid, cause[4:0]}, parametrised by NUM_LOCAL_IRQ.

Test Plan:
1. Reset, then read 301 -> 32'h40000100. Read 344 with irq_ext=1 -> 32'h00000800.
2. Write mtvec=32'h1001, mie bit 7, mstatus=8; raise irq_timer; give 13 advances -> drain_req high for the drain; pulse with trap_target=32'h101C, mcause=32'h80000007, mstatus=32'h80.
3. ecall at pc_id=32'h200 -> mepc=32'h200, mcause=11, trap_target={mtvec[31:2],00}. Then mret in the same cycle as a write of 341=32'h204 -> trap_target=32'h204, MIE restored.
4. irq_ext and irq_local[0] asserted together with both enabled -> cause 11 taken. With irq_local[2] alone -> mcause=32'h80000012.
5. Write mcycle lo=32'hFFFFFFFF, hi=0 -> next cycle hi=1, lo=0. A write during retire=1 -> the written value holds.
6. Deassert reset during DRAIN -> drain_req=0, mepc unchanged at 0, no redirect pulse.
